// File: rtl/matrices_stream_out.sv
// Streams a captured frame of MATRICES_COUNT MxN matrices one element per accepted beat.
// Optional sticky overrun flag enabled by defining MATRICES_STREAM_OVERRUN_EN.
module matrices_stream_out #(
    parameter int MATRICES_COUNT = 5,
    parameter int MATRIX_SIZE_M  = 4,
    parameter int MATRIX_SIZE_N  = 3,
    parameter int DATA_WIDTH     = 16,
    localparam int BLOCK_SIZE    = MATRIX_SIZE_M * MATRIX_SIZE_N * DATA_WIDTH,
    localparam int TOTAL_ELEMS   = MATRICES_COUNT * MATRIX_SIZE_M * MATRIX_SIZE_N,
    localparam int IDX_W         = (MATRICES_COUNT > 1) ? $clog2(MATRICES_COUNT) : 1,
    localparam int ROW_W         = (MATRIX_SIZE_M > 1) ? $clog2(MATRIX_SIZE_M) : 1,
    localparam int COL_W         = (MATRIX_SIZE_N > 1) ? $clog2(MATRIX_SIZE_N) : 1,
    localparam int ELEM_W        = (TOTAL_ELEMS > 1) ? $clog2(TOTAL_ELEMS) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [BLOCK_SIZE*MATRICES_COUNT-1:0] i_matrices,
    input  logic                                 i_src_ready,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic                                 o_valid,
    input  logic                                 i_out_ready,
    output logic [IDX_W-1:0]                     o_matrix_idx,
    output logic [ROW_W-1:0]                     o_row,
    output logic [COL_W-1:0]                     o_col,
    output logic                                 o_last_elem,
    output logic                                 o_last,
    output logic                                 o_overrun,
    input  logic                                 i_overrun_clr
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic                   src_ready_d;
    logic                   capture, advance, last_beat, accept_last, load;
    logic [DATA_WIDTH-1:0]  frame_q [TOTAL_ELEMS];
    logic [ELEM_W-1:0]      elem_q;
    logic [IDX_W-1:0]       idx_q;
    logic [ROW_W-1:0]       row_q;
    logic [COL_W-1:0]       col_q;

    // Delayed copy resets high so a level already asserted across reset is not a capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) src_ready_d <= 1'b1;
        else       src_ready_d <= i_src_ready;
    end

    assign capture     = i_src_ready & ~src_ready_d;
    assign advance     = (state_q == STREAM) & i_out_ready;
    assign last_beat   = (elem_q == ELEM_W'(TOTAL_ELEMS - 1));
    assign accept_last = advance & last_beat;
    assign load        = capture & ((state_q == IDLE) | accept_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = STREAM;
            STREAM:  if (accept_last && !capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_valid      = (state_q == STREAM);
        o_data       = frame_q[elem_q];
        o_matrix_idx = idx_q;
        o_row        = row_q;
        o_col        = col_q;
        o_last_elem  = o_valid && (row_q == ROW_W'(MATRIX_SIZE_M - 1))
                               && (col_q == COL_W'(MATRIX_SIZE_N - 1));
        o_last       = o_last_elem && (idx_q == IDX_W'(MATRICES_COUNT - 1));
    end

    // Frame buffer is only written on a real load, so a mid-frame capture cannot corrupt it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int e = 0; e < TOTAL_ELEMS; e++) frame_q[e] <= '0;
        end else if (load) begin
            for (int e = 0; e < TOTAL_ELEMS; e++)
                frame_q[e] <= i_matrices[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Indices hold on the final beat so o_data keeps its last value while idle.
    always_ff @(posedge i_clk) begin
        if (i_rst || load) begin
            elem_q <= '0;
            idx_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (advance && !last_beat) begin
            elem_q <= elem_q + 1'b1;
            if (col_q == COL_W'(MATRIX_SIZE_N - 1)) begin
                col_q <= '0;
                if (row_q == ROW_W'(MATRIX_SIZE_M - 1)) begin
                    row_q <= '0;
                    idx_q <= idx_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef MATRICES_STREAM_OVERRUN_EN
    logic overrun_q;

    // A set in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                               overrun_q <= 1'b0;
        else if (capture && (state_q == STREAM) && !accept_last) overrun_q <= 1'b1;
        else if (i_overrun_clr)                                  overrun_q <= 1'b0;
    end

    assign o_overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = i_overrun_clr;
    assign o_overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_matrices_stream_out.sv
// Self-checking bench for matrices_stream_out with 2 matrices of 2x2 bytes.
// Expected beats come from a loop-based model of the frame ordering.
module tb_matrices_stream_out;
    localparam int MC = 2, M = 2, N = 2, DW = 8;
    localparam int NB = MC * M * N;
    localparam int BUSW = NB * DW;
`ifdef MATRICES_STREAM_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [BUSW-1:0] i_matrices = '0;
    logic            i_src_ready = 1'b1;
    logic [DW-1:0]   o_data;
    logic            o_valid;
    logic            i_out_ready = 1'b0;
    logic [0:0]      o_matrix_idx, o_row, o_col;
    logic            o_last_elem, o_last, o_overrun;
    logic            i_overrun_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_data [NB];
    logic [2:0]    exp_pos  [NB];
    logic          exp_le   [NB];
    logic          exp_l    [NB];

    matrices_stream_out #(
        .MATRICES_COUNT(MC), .MATRIX_SIZE_M(M), .MATRIX_SIZE_N(N), .DATA_WIDTH(DW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_matrices(i_matrices), .i_src_ready(i_src_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_matrix_idx(o_matrix_idx), .o_row(o_row), .o_col(o_col),
        .o_last_elem(o_last_elem), .o_last(o_last), .o_overrun(o_overrun),
        .i_overrun_clr(i_overrun_clr)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want TB_RESULT before it");
        $fatal(1);
    end

    // Reference ordering: matrix-major, then row-major within each matrix.
    function automatic void build_expected(input logic [BUSW-1:0] bus);
        int n = 0;
        for (int k = 0; k < MC; k++)
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++) begin
                    exp_data[n] = bus[(k*M*N + r*N + c)*DW +: DW];
                    exp_pos[n]  = 3'((k << 2) | (r << 1) | c);
                    exp_le[n]   = (r == M-1) && (c == N-1);
                    exp_l[n]    = exp_le[n] && (k == MC-1);
                    n++;
                end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame(input logic [BUSW-1:0] bus);
        i_matrices = bus;
        build_expected(bus);
        i_src_ready = 1'b0;
        tick();
        i_src_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_src_ready = 1'b1;
        i_out_ready = 1'($urandom);
        i_overrun_clr = 1'($urandom);
        i_matrices = {$urandom, $urandom};
        repeat (3) tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        checks++;
        if (o_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: got %h want 00", o_data);
        end
        checks++;
        if ({o_matrix_idx, o_row, o_col, o_last_elem, o_last, o_overrun} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got idx/row/col/le/l/ovr=%b want 000000",
                     {o_matrix_idx, o_row, o_col, o_last_elem, o_last, o_overrun});
        end
        i_rst = 1'b0;
        i_out_ready = 1'b1;
        i_overrun_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                failures++; $display("FAIL reset_held_high_cycle%0d: valid got %b want 0", i, o_valid);
            end
        end
    endtask

    task automatic test_basic();
        start_frame(64'h0807060504030201);
        i_out_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_data[i] || {o_matrix_idx, o_row, o_col} !== exp_pos[i]
                || o_last_elem !== exp_le[i] || o_last !== exp_l[i]) begin
                failures++;
                $display("FAIL basic_beat%0d: got v=%b d=%h pos=%b le=%b l=%b want v=1 d=%h pos=%b le=%b l=%b",
                         i, o_valid, o_data, {o_matrix_idx, o_row, o_col}, o_last_elem, o_last,
                         exp_data[i], exp_pos[i], exp_le[i], exp_l[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL basic_end_valid: got %b want 0", o_valid);
        end
    endtask

    task automatic test_stall();
        logic [3:0] pattern = 4'b1001;
        for (int f = 0; f < 4; f++) begin
            int n = 0;
            int cyc = 0;
            logic rdy;
            start_frame({$urandom, $urandom});
            while (n < NB && cyc < 200) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== exp_data[n] || {o_matrix_idx, o_row, o_col} !== exp_pos[n]
                    || o_last_elem !== exp_le[n] || o_last !== exp_l[n]) begin
                    failures++;
                    $display("FAIL stall_f%0d_beat%0d: got v=%b d=%h pos=%b le=%b l=%b want v=1 d=%h pos=%b le=%b l=%b",
                             f, n, o_valid, o_data, {o_matrix_idx, o_row, o_col}, o_last_elem, o_last,
                             exp_data[n], exp_pos[n], exp_le[n], exp_l[n]);
                end
                rdy = (f == 0) ? pattern[cyc % 4] : 1'($urandom_range(0, 1));
                i_out_ready = rdy;
                if (rdy) n++;
                tick();
                cyc++;
            end
            checks++;
            if (n != NB || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_f%0d_end: got beats=%0d valid=%b want beats=%0d valid=0", f, n, o_valid, NB);
            end
        end
        i_out_ready = 1'b1;
    endtask

    task automatic test_overrun();
        logic [BUSW-1:0] bus2 = {$urandom, $urandom};
        checks++;
        if (o_overrun !== 1'b0) begin
            failures++; $display("FAIL overrun_initial: got %b want 0", o_overrun);
        end
        start_frame({$urandom, $urandom});
        i_out_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_data[i] || {o_matrix_idx, o_row, o_col} !== exp_pos[i]
                || o_last_elem !== exp_le[i] || o_last !== exp_l[i]) begin
                failures++;
                $display("FAIL overrun_beat%0d: got v=%b d=%h pos=%b le=%b l=%b want v=1 d=%h pos=%b le=%b l=%b",
                         i, o_valid, o_data, {o_matrix_idx, o_row, o_col}, o_last_elem, o_last,
                         exp_data[i], exp_pos[i], exp_le[i], exp_l[i]);
            end
            if (i == 0) i_src_ready = 1'b0;
            if (i == 2) begin
                i_matrices = bus2;
                i_src_ready = 1'b1;
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0 || o_overrun !== OVR_EN) begin
            failures++;
            $display("FAIL overrun_flag: got valid=%b ovr=%b want valid=0 ovr=%b", o_valid, o_overrun, OVR_EN);
        end
        i_overrun_clr = 1'b1;
        tick();
        i_overrun_clr = 1'b0;
        checks++;
        if (o_overrun !== 1'b0) begin
            failures++; $display("FAIL overrun_clear: got %b want 0", o_overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [BUSW-1:0] bus2 = {$urandom, $urandom};
        start_frame({$urandom, $urandom});
        i_out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NB; i++) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== exp_data[i] || {o_matrix_idx, o_row, o_col} !== exp_pos[i]
                    || o_last_elem !== exp_le[i] || o_last !== exp_l[i]) begin
                    failures++;
                    $display("FAIL b2b_f%0d_beat%0d: got v=%b d=%h pos=%b le=%b l=%b want v=1 d=%h pos=%b le=%b l=%b",
                             f, i, o_valid, o_data, {o_matrix_idx, o_row, o_col}, o_last_elem, o_last,
                             exp_data[i], exp_pos[i], exp_le[i], exp_l[i]);
                end
                if (f == 0 && i == 4) i_src_ready = 1'b0;
                if (f == 0 && i == NB-1) begin
                    i_matrices = bus2;
                    i_src_ready = 1'b1;
                end
                tick();
            end
            if (f == 0) build_expected(bus2);
        end
        checks++;
        if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got valid=%b ovr=%b want valid=0 ovr=0", o_valid, o_overrun);
        end
    endtask

    task automatic test_reset_mid();
        start_frame({$urandom, $urandom});
        i_out_ready = 1'b1;
        repeat (4) tick();
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || {o_matrix_idx, o_row, o_col} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_state: got valid=%b d=%h pos=%b want valid=0 d=00 pos=000",
                     o_valid, o_data, {o_matrix_idx, o_row, o_col});
        end
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                failures++; $display("FAIL midreset_norestart_cycle%0d: valid got %b want 0", i, o_valid);
            end
        end
        start_frame({$urandom, $urandom});
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_data[i] || {o_matrix_idx, o_row, o_col} !== exp_pos[i]
                || o_last_elem !== exp_le[i] || o_last !== exp_l[i]) begin
                failures++;
                $display("FAIL midreset_beat%0d: got v=%b d=%h pos=%b le=%b l=%b want v=1 d=%h pos=%b le=%b l=%b",
                         i, o_valid, o_data, {o_matrix_idx, o_row, o_col}, o_last_elem, o_last,
                         exp_data[i], exp_pos[i], exp_le[i], exp_l[i]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_end_valid: got %b want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrices_stream_out.md
MATRICES_STREAM_OUT -- requirements
Module: matrices_stream_out

Interface
REQ-001 SHALL have parameter MATRICES_COUNT, default 5: number of matrices in the flat result bus.
REQ-002 SHALL have parameter MATRIX_SIZE_M, default 4: rows per matrix.
REQ-003 SHALL have parameter MATRIX_SIZE_N, default 3: columns per matrix.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: element width; BLOCK_SIZE = M*N*DATA_WIDTH (local).
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_matrices  input  BLOCK_SIZE*MATRICES_COUNT  flat result bus from the matrices summing stage; matrix k at [k*BLOCK_SIZE +: BLOCK_SIZE].
REQ-008 SHALL have port i_src_ready  input  1  result-valid level from the summing stage.
REQ-009 SHALL have port o_data  output  DATA_WIDTH  current streamed element.
REQ-010 SHALL have port o_valid  output  1  o_data valid.
REQ-011 SHALL have port i_out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port o_matrix_idx  output  $clog2(MATRICES_COUNT) (min 1)  matrix index of o_data.
REQ-013 SHALL have port o_row  output  $clog2(MATRIX_SIZE_M) (min 1)  row of o_data.
REQ-014 SHALL have port o_col  output  $clog2(MATRIX_SIZE_N) (min 1)  column of o_data.
REQ-015 SHALL have port o_last_elem  output  1  o_data is last element of its matrix.
REQ-016 SHALL have port o_last  output  1  o_data is last element of the frame.
REQ-017 SHALL have port o_overrun  output  1  sticky: a new result arrived while streaming.
REQ-018 SHALL have port i_overrun_clr  input  1  clears o_overrun.

Function
REQ-019 SHALL keep a 1-cycle delayed copy of i_src_ready; capture event = i_src_ready==1 and delayed copy==0.
REQ-020 SHALL have states IDLE and STREAM; IDLE->STREAM on capture event; STREAM->IDLE on acceptance of the o_last beat with no capture event.
REQ-021 SHALL, on capture event, register all of i_matrices into an internal frame buffer; o_valid=1 the next cycle (latency 1).
REQ-022 SHALL stream row-major per matrix, matrix 0 first: element (r,c) of matrix k is bits [k*BLOCK_SIZE + (r*N+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-023 SHALL advance one element per cycle only when o_valid && i_out_ready; o_data, indices and flags stable while stalled.
REQ-024 SHALL emit exactly MATRICES_COUNT*M*N beats per frame; o_col wraps N-1->0 incrementing o_row; o_row wraps M-1->0 incrementing o_matrix_idx.
REQ-025 SHALL assert o_last_elem when o_row==M-1 and o_col==N-1; o_last when additionally o_matrix_idx==MATRICES_COUNT-1.
REQ-026 SHALL, on capture event in the same cycle the o_last beat is accepted, load the new frame and present its element (0,0,0) next cycle with o_valid held 1 (back-to-back, no bubble).
REQ-027 SHALL, on capture event in STREAM at any other cycle, ignore the new data, keep streaming the current frame unchanged, and (with REQ-034) set o_overrun.
REQ-028 SHALL drive o_valid=0 in IDLE; o_data then holds last value and is don't-care.
REQ-029 SHALL give i_overrun_clr priority below a same-cycle set (set wins).

Reset
REQ-030 SHALL, with i_rst=1 at a clock edge, go to IDLE, o_valid=0, indices=0, o_last=0, o_last_elem=0, o_overrun=0, o_data=0, aborting any frame.
REQ-031 SHALL reset the delayed i_src_ready copy to 1, so a level held high across reset causes no capture; a genuine 0->1 is required.
REQ-032 SHALL ignore i_src_ready, i_out_ready and i_overrun_clr while i_rst=1.

Configuration
REQ-033 SHALL use macro MATRICES_STREAM_OVERRUN_EN.
REQ-034 SHALL, when defined, implement o_overrun per REQ-027/029; when undefined, tie o_overrun to 0, ignore i_overrun_clr, no flag register; streaming behaviour identical.

Verification (MATRICES_COUNT=2, M=2, N=2, DATA_WIDTH=8; bus bytes 0x01..0x08 from LSB)
REQ-035 SHALL check: i_src_ready 0->1, i_out_ready=1 -> o_valid next cycle, o_data 0x01..0x08 on 8 consecutive cycles, o_last_elem on 0x04/0x08, o_last on 0x08, then o_valid=0.
REQ-036 SHALL check: i_out_ready toggled 1,0,0,1,... -> each element held stable while stalled, no element skipped or repeated, 8 accepted beats.
REQ-037 SHALL check: second 0->1 (bus 0x11..0x18) during beat 3 -> beats remain 0x01..0x08, o_overrun=1 after, cleared by i_overrun_clr pulse; macro undefined -> o_overrun stays 0.
REQ-038 SHALL check: 0->1 with new bus on cycle o_last (0x08) accepted -> next cycle o_valid=1, o_data=0x11, no idle cycle.
REQ-039 SHALL check: i_rst=1 at beat 5 with i_src_ready held 1 -> o_valid=0 next cycle, no restart until i_src_ready 1->0->1.
